// File: rtl/lu_acc.sv
// Logic unit with an accumulator and a bit-serial rotate. Logic ops finish in 1 cycle, rotate-by-k in k+1.
// One request in flight: in_ready only in IDLE, and the result holds in DONE until out_ready.
module lu_acc #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             zero
);

   localparam int SW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic             zero_q, zero_d;
   logic [SW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [WIDTH-1:0] res;
   logic [WIDTH-1:0] rot;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         y_q     <= '0;
         zero_q  <= 1'b1;
         cnt_q   <= '0;
         work_q  <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         y_q     <= y_d;
         zero_q  <= zero_d;
         cnt_q   <= cnt_d;
         work_q  <= work_d;
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      y_d     = y_q;
      zero_d  = zero_q;
      cnt_d   = cnt_q;
      work_d  = work_q;
      res     = '0;
      rot     = {work_q[WIDTH-2:0], work_q[WIDTH-1]};

      case (op)
         3'b000:  res = a & b;
         3'b001:  res = a | b;
         3'b010:  res = a ^ b;
         3'b011:  res = ~a;
         3'b100:  res = acc_q & a;
         3'b101:  res = acc_q | a;
         3'b110:  res = acc_q ^ a;
         default: res = '0;
      endcase

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (op == 3'b111) begin
                  // A zero rotate amount skips ROT so latency stays at one cycle.
                  if (b[SW-1:0] == '0) begin
                     y_d     = a;
                     zero_d  = (a == '0);
                     state_d = DONE;
                  end else begin
                     work_d  = a;
                     cnt_d   = b[SW-1:0];
                     state_d = ROT;
                  end
               end else begin
                  y_d     = res;
                  zero_d  = (res == '0);
                  if (op[2]) acc_d = res;
                  state_d = DONE;
               end
            end
         end
         ROT: begin
            work_d = rot;
            cnt_d  = cnt_q - SW'(1);
            if (cnt_q == SW'(1)) begin
               y_d     = rot;
               zero_d  = (rot == '0);
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign y         = y_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_lu_acc.sv
// Directed bench for lu_acc (WIDTH=8): logic ops, accumulator chain, rotate latency, backpressure, mid-op reset.
module tb_lu_acc;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic [2:0] op;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] y;
   logic       zero;

   int total = 0;
   int bad   = 0;
   int lat;

   lu_acc #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called #1 after an edge with the DUT in IDLE; request is taken on the next edge,
   // after which the operands are scrambled to show they were captured.
   task automatic send(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv);
      in_valid = 1'b1;
      op = o;
      a  = av;
      b  = bv;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      op = ~o;
      a  = ~av;
      b  = ~bv;
   endtask

   task automatic wait_out(output int l);
      l = 1;
      while (!out_valid && l < 40) begin
         @(posedge clk);
         #1;
         l++;
      end
   endtask

   task automatic run(input string tag, input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv,
                      input logic [7:0] ey, input logic ez, input int elat);
      int l;
      check({tag, "_rdy"}, 64'(in_ready), 64'd1);
      send(o, av, bv);
      wait_out(l);
      check({tag, "_lat"}, 64'(l), 64'(elat));
      check({tag, "_y"}, 64'(y), 64'(ey));
      check({tag, "_z"}, 64'(zero), 64'(ez));
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a  = '0;
      b  = '0;
      op = '0;
      #12;
      check("rst_ov", 64'(out_valid), 64'd0);
      check("rst_y", 64'(y), 64'd0);
      check("rst_z", 64'(zero), 64'd1);
      check("rst_rdy", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Plain logic ops.
      run("and", 3'b000, 8'hF0, 8'hCC, 8'hC0, 1'b0, 1);
      run("or",  3'b001, 8'hF0, 8'hCC, 8'hFC, 1'b0, 1);
      run("xor", 3'b010, 8'hF0, 8'hCC, 8'h3C, 1'b0, 1);
      run("not", 3'b011, 8'hF0, 8'hCC, 8'h0F, 1'b0, 1);
      run("xz",  3'b010, 8'hAA, 8'hAA, 8'h00, 1'b1, 1);

      // Rotates: k=3, k=0, k=1 with wrap, k=7.
      run("rot3", 3'b111, 8'h96, 8'h03, 8'hB4, 1'b0, 4);
      run("rot0", 3'b111, 8'h96, 8'h08, 8'h96, 1'b0, 1);
      run("rot1", 3'b111, 8'h81, 8'h01, 8'h03, 1'b0, 2);
      run("rot7", 3'b111, 8'h01, 8'hFF, 8'h80, 1'b0, 8);

      // Accumulator chain from acc=0.
      run("acc_or",  3'b101, 8'hF0, 8'h00, 8'hF0, 1'b0, 1);
      run("acc_xor", 3'b110, 8'hCC, 8'h00, 8'h3C, 1'b0, 1);
      run("acc_and", 3'b100, 8'h0F, 8'h00, 8'h0C, 1'b0, 1);

      // Backpressure: result holds and a second request is refused.
      out_ready = 1'b0;
      send(3'b000, 8'hF0, 8'hCC);
      wait_out(lat);
      check("bp_lat", 64'(lat), 64'd1);
      in_valid = 1'b1;
      op = 3'b011;
      a  = 8'h00;
      b  = 8'h00;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("bp_y", 64'(y), 64'hC0);
         check("bp_z", 64'(zero), 64'd0);
         check("bp_ov", 64'(out_valid), 64'd1);
         check("bp_rdy", 64'(in_ready), 64'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_rel_rdy", 64'(in_ready), 64'd1);
      check("bp_rel_ov", 64'(out_valid), 64'd0);
      check("bp_rel_y", 64'(y), 64'hC0);

      // Reset in the middle of a k=5 rotate.
      send(3'b111, 8'h96, 8'h05);
      @(posedge clk);
      #1;
      check("mid_ov", 64'(out_valid), 64'd0);
      rst_n = 1'b0;
      #1;
      check("ar_ov", 64'(out_valid), 64'd0);
      check("ar_y", 64'(y), 64'd0);
      check("ar_z", 64'(zero), 64'd1);
      check("ar_rdy", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      check("ar_hold_ov", 64'(out_valid), 64'd0);
      rst_n = 1'b1;
      run("post_rst_acc", 3'b101, 8'h01, 8'h00, 8'h01, 1'b0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lu_acc.md
LU_ACC -- requirements
Module: lu_acc

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits, with a legal range of 2 to 64.
REQ-002 The block SHALL derive localparam SW = clog2(WIDTH), the number of rotate-amount bits taken from b.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the request is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept a request.
REQ-007 The block SHALL have ports a and b, input, WIDTH bits each: the operands.
REQ-008 The block SHALL have port op, input, 3 bits: the operation select.
REQ-009 The block SHALL have port out_valid, output, 1 bit: y is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts y.
REQ-011 The block SHALL have port y, output, WIDTH bits: the registered result.
REQ-012 The block SHALL have port zero, output, 1 bit: registered, 1 when y == 0.

Function
REQ-013 Ops SHALL be: 000 a&b; 001 a|b; 010 a^b; 011 ~a; 100 acc&a; 101 acc|a; 110 acc^a; 111 rotate a left by b[SW-1:0].
REQ-014 Internal register acc (WIDTH bits) SHALL load the result on completion of ops 100–110 only; all other ops leave acc unchanged.
REQ-015 The FSM SHALL have states IDLE, ROT and DONE.
- in_ready = 1 only in IDLE, combinationally from state.
- out_valid = 1 only in DONE.
REQ-016 A request SHALL be accepted on a rising edge with in_valid & in_ready; a, b and op are captured at that edge and later input changes are ignored.
REQ-017 Ops 000–110 SHALL go IDLE→DONE with y and zero registered at the accept edge, so out_valid rises 1 cycle after accept.
REQ-018 Op 111 SHALL behave as follows:
- Capture k = b[SW-1:0] and a working register = a.
- If k == 0, go to DONE directly with y = a (1-cycle latency).
- Otherwise go to ROT and rotate left 1 bit per cycle for k cycles, then load y and go to DONE (latency k+1 cycles).
REQ-019 The block SHALL leave DONE for IDLE on a rising edge with out_ready = 1; while out_ready = 0, y, zero and out_valid SHALL hold stable.
REQ-020 There SHALL be no overlap: a new request is accepted no earlier than the cycle after the DONE→IDLE transition.
REQ-021 Rotation SHALL wrap modulo WIDTH; bits shifted out of the MSB enter at the LSB, and no bits are lost or added.
REQ-022 For WIDTH not a power of 2, k ≥ WIDTH SHALL still perform exactly k single-bit rotations.
REQ-023 Results SHALL be exactly WIDTH bits with no carries or flags other than zero.

Reset
REQ-024 On rst_n = 0, immediately and regardless of clk, the block SHALL set:
- state = IDLE, acc = 0, y = 0, zero = 1, out_valid = 0, in_ready = 1;
- the rotate count and working register cleared.
REQ-025 Reset asserted mid-ROT or in DONE SHALL abort the operation, discard the result, and leave acc unchanged by the aborted op (i.e. 0 after reset).
REQ-026 The first request SHALL be accepted on the first rising edge after rst_n deasserts with in_valid = 1.

Verification
REQ-027 With WIDTH=8, a=11110000, b=11001100, out_ready=1 and op 000/001/010/011 in turn, the bench SHALL see y=11000000/11111100/00111100/00001111, each 1 cycle after accept, all with zero=0.
REQ-028 With a=10010110, b=00000011, op=111, the bench SHALL see y=10110100 with out_valid 4 cycles after accept; with b=00001000 (k=0), y=10010110 after 1 cycle.
REQ-029 After reset, the sequence op=101 a=11110000, then op=110 a=11001100, then op=100 a=00001111 SHALL give y=11110000, then 00111100, then 00001100.
REQ-030 A request with a=b=10101010, op=010 SHALL give y=00000000, zero=1.
REQ-031 With out_ready held 0 for 5 cycles after out_valid rises, y and zero SHALL stay stable, in_ready SHALL stay 0 and a second in_valid request SHALL NOT be accepted; after out_ready=1, in_ready SHALL be 1 the next cycle.
REQ-032 For op=111 with k=5 and rst_n pulsed low 2 cycles after accept, the bench SHALL see out_valid=0, y=0, zero=1 and in_ready=1 immediately; a following op=101 a=00000001 SHALL give y=00000001, proving acc was cleared.
